// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the RV64 instruction fetch unit.
package ifu_pkg;
   localparam int          XLEN       = 64;
   localparam int          ILEN       = 32;
   localparam int          INST_BYTES = 4;
   localparam logic [31:0] NOP_INST   = 32'h00000013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bus: instruction memory, decode handshake and redirect.
interface ifu_fetch_ctrl_if;
   import ifu_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [ILEN-1:0] out_inst;
   logic [XLEN-1:0] out_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            fetch_done;
   logic            misalign_err;

   modport master (
      output imem_addr, out_valid, out_inst, out_pc, fetch_done, misalign_err,
      input  imem_rdata, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, out_valid, out_inst, out_pc, fetch_done, misalign_err,
      output imem_rdata, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifu_fetch_ctrl_fifo.sv
// Prefetch queue of {pc, inst} entries; flush overrides push and pop.
module ifu_fetch_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_wdata,
   output logic         o_full,
   output logic         o_empty,
   output fetch_entry_t o_head
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   // A push into a full queue is allowed when the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_head  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch initiator: PC register, fetch enable, end-of-memory and misalign flags
// feeding a prefetch queue toward decode.
module ifu_fetch_ctrl
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          MEM_BYTES = 32,
   parameter int          DEPTH     = 4
) (
   input logic              clk,
   input logic              reset_n,
   ifu_fetch_ctrl_if.master bus
);
   localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - INST_BYTES);

   logic [XLEN-1:0] r_pc;
   logic            r_fetch_done;
   logic            r_misalign;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push;
   logic            w_at_end;
   fetch_entry_t    w_wdata;
   fetch_entry_t    w_head;

   // Past the last word nothing is pushed, even before fetch_done registers.
   assign w_at_end = (r_pc > LAST_PC);
   assign w_pop    = !w_empty && bus.out_ready;
   assign w_push   = !bus.redirect_valid && !r_fetch_done && !w_at_end && (!w_full || w_pop);
   assign w_wdata  = {r_pc, bus.imem_rdata};

   ifu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_valid),
      .i_wdata (w_wdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc         <= RESET_PC;
         r_fetch_done <= 1'b0;
         r_misalign   <= 1'b0;
      end else if (bus.redirect_valid) begin
         r_pc         <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         r_fetch_done <= 1'b0;
         r_misalign   <= |bus.redirect_pc[1:0];
      end else begin
         r_misalign   <= 1'b0;
         r_fetch_done <= w_at_end;
         if (w_push) r_pc <= r_pc + XLEN'(INST_BYTES);
      end
   end

   assign bus.imem_addr    = r_pc;
   assign bus.out_valid    = !w_empty;
   assign bus.out_inst     = w_head.inst;
   assign bus.out_pc       = w_head.pc;
   assign bus.fetch_done   = r_fetch_done;
   assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench: the expected delivery stream is rebuilt on every redirect/reset
// and a negedge monitor compares the queue head and flags against it.
module tb_ifu_fetch_ctrl;
   import ifu_pkg::*;

   localparam int          MEM_BYTES = 32;
   localparam int          DEPTH     = 4;
   localparam int          NW        = MEM_BYTES / 4;
   localparam logic [63:0] RESET_PC  = 64'h0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   ifu_fetch_ctrl_if bus();

   ifu_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [NW] = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
                              32'h00000013, 32'h00100093, 32'h00208113, 32'h00310193};

   function automatic logic [31:0] rd(input logic [63:0] a);
      if (a < 64'(MEM_BYTES)) return imem[int'(a >> 2)];
      return 32'h0;
   endfunction

   assign bus.imem_rdata = rd(bus.imem_addr);

   int           n_vec = 0;
   int           n_err = 0;
   fetch_entry_t exp_q[$];
   logic         mon_en  = 1'b0;
   logic         exp_mis = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural stream: every word from the (aligned) start to the end of memory.
   function automatic void rebuild(input logic [63:0] a);
      exp_q.delete();
      for (longint unsigned p = a; p <= longint'(MEM_BYTES - 4); p += 4)
         exp_q.push_back({64'(p), rd(64'(p))});
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("misalign_err", {63'h0, bus.misalign_err}, {63'h0, exp_mis});
            if (exp_q.size() == 0)
               check("valid_when_drained", {63'h0, bus.out_valid}, 64'h0);
            else if (bus.out_valid) begin
               check("head_pc", bus.out_pc, exp_q[0].pc);
               check("head_inst", {32'h0, bus.out_inst}, {32'h0, exp_q[0].inst});
               if (reset_n && bus.out_ready) void'(exp_q.pop_front());
            end
            exp_mis = reset_n && bus.redirect_valid && (|bus.redirect_pc[1:0]);
         end
      end
   end

   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      repeat (n) @(posedge clk);
      rebuild(RESET_PC);
      #1 reset_n = 1'b1;
   endtask

   task automatic do_redirect(input logic [63:0] t);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = t;
      @(posedge clk);
      rebuild(t & ~64'h3);
      #1 bus.redirect_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      // Reset release and free-running drain to end of memory
      do_reset(2);
      check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("rst_out_inst", {32'h0, bus.out_inst}, 64'h0);
      check("rst_out_pc", bus.out_pc, 64'h0);
      check("rst_fetch_done", {63'h0, bus.fetch_done}, 64'h0);
      check("rst_misalign", {63'h0, bus.misalign_err}, 64'h0);
      check("rst_imem_addr", bus.imem_addr, RESET_PC);
      mon_en = 1'b1;
      bus.out_ready = 1'b1;
      cycle(1);
      check("first_valid", {63'h0, bus.out_valid}, 64'h1);
      check("first_pc", bus.out_pc, 64'h0);
      cycle(20);
      check("end_fetch_done", {63'h0, bus.fetch_done}, 64'h1);
      check("end_valid", {63'h0, bus.out_valid}, 64'h0);
      check("end_drained", 64'(exp_q.size()), 64'h0);

      // Backpressure then one transfer per cycle from a full queue
      bus.out_ready = 1'b0;
      do_reset(1);
      cycle(10);
      check("bp_imem_addr", bus.imem_addr, 64'h10);
      check("bp_head_pc", bus.out_pc, 64'h0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cycle(1);
         check("stream_no_gap", {63'h0, bus.out_valid}, 64'h1);
      end
      cycle(1);
      check("stream_end", {63'h0, bus.out_valid}, 64'h0);

      // Redirect while full
      bus.out_ready = 1'b0;
      do_reset(1);
      cycle(6);
      do_redirect(64'h8);
      check("redir_flushed", {63'h0, bus.out_valid}, 64'h0);
      cycle(1);
      check("redir_pc", bus.out_pc, 64'h8);
      check("redir_inst", {32'h0, bus.out_inst}, 64'h035a02b3);

      // Misaligned redirect
      do_redirect(64'h6);
      check("mis_pulse", {63'h0, bus.misalign_err}, 64'h1);
      cycle(1);
      check("mis_clear", {63'h0, bus.misalign_err}, 64'h0);
      check("mis_pc", bus.out_pc, 64'h4);
      check("mis_inst", {32'h0, bus.out_inst}, 64'h413903b3);

      // Redirect coinciding with a head handshake on a full queue
      cycle(6);
      bus.out_ready = 1'b1;
      do_redirect(64'h10);
      check("pop_redir_flush", {63'h0, bus.out_valid}, 64'h0);
      cycle(1);
      check("pop_redir_pc", bus.out_pc, 64'h10);

      // Mid-stream reset with a full queue
      bus.out_ready = 1'b0;
      cycle(6);
      do_reset(1);
      check("mid_rst_valid", {63'h0, bus.out_valid}, 64'h0);
      check("mid_rst_addr", bus.imem_addr, RESET_PC);
      check("mid_rst_done", {63'h0, bus.fetch_done}, 64'h0);
      cycle(1);
      check("mid_rst_restart", bus.out_pc, 64'h0);

      // Redirect past the end: fetch_done clears, then re-sets
      do_redirect(64'h24);
      check("past_end_cleared", {63'h0, bus.fetch_done}, 64'h0);
      cycle(1);
      check("past_end_done", {63'h0, bus.fetch_done}, 64'h1);
      check("past_end_valid", {63'h0, bus.out_valid}, 64'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0)      do_reset(1);
         else if ($urandom_range(0, 19) == 0) do_redirect(64'($urandom_range(0, 40)));
         else                                  cycle(1);
      end
      bus.out_ready = 1'b1;
      cycle(20);
      check("final_drained", 64'(exp_q.size()), 64'h0);
      check("final_fetch_done", {63'h0, bus.fetch_done}, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
